// File: rtl/coin_input_conditioner.sv
// ---------------------------------------------------------------------------
// coin_input_conditioner
//   Conditions the three raw coin-slot switches for the vending FSM. Each
//   channel is synchronised, debounced and edge-detected. A priority arbiter
//   (nickel > dime > quarter) then issues at most one single-cycle coin pulse
//   per clock, holding any other coins as pending so none are lost. A channel
//   whose debounced level stays high too long is flagged stuck and masked.
//
// Ports
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_nickle_raw   raw nickel switch (async, bouncy, active-high)
//   i_dime_raw     raw dime switch
//   i_quarter_raw  raw quarter switch
//   o_nickle       one-cycle nickel-accepted pulse (registered)
//   o_dime         one-cycle dime-accepted pulse (registered)
//   o_quarter      one-cycle quarter-accepted pulse (registered)
//   o_busy         a coin is being issued / was pending at the last edge
//   o_stuck        sticky stuck flags: [0] nickel, [1] dime, [2] quarter
// ---------------------------------------------------------------------------

// Per-channel synchroniser, debouncer, rise detector and stuck detector.
//   i_raw     raw switch input
//   o_rise_c  combinational strobe: debounced level flips 0->1 on this edge
//             (already masked once the channel is stuck)
//   o_stuck   sticky stuck flag (registered)
module coin_channel #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_rise_c,
  output logic o_stuck
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  logic                   r_deb;
  logic [DEB_W-1:0]       r_deb_cnt;
  logic                   w_flip;
  logic [STK_W-1:0]       r_stk_cnt;
  logic                   r_stuck;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Plain shift-register synchroniser, no logic between stages.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // The flip happens on the edge that would complete DEBOUNCE_CYCLES
  // consecutive mismatching samples.
  assign w_flip = (w_synced != r_deb) &&
                  (r_deb_cnt >= DEB_W'(DEBOUNCE_CYCLES - 1));

  // Debounce counter: clears on agreement, saturates rather than wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (w_synced == r_deb) begin
      r_deb_cnt <= '0;
    end else if (w_flip) begin
      r_deb     <= w_synced;
      r_deb_cnt <= '0;
    end else if (r_deb_cnt != DEB_W'(DEBOUNCE_CYCLES)) begin
      r_deb_cnt <= r_deb_cnt + DEB_W'(1);
    end
  end

  // Stuck counter runs while the debounced level is high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stk_cnt <= '0;
      r_stuck   <= 1'b0;
    end else begin
      if (!r_deb) begin
        r_stk_cnt <= '0;
      end else if (r_stk_cnt != STK_W'(STUCK_CYCLES)) begin
        r_stk_cnt <= r_stk_cnt + STK_W'(1);
      end
      if (r_deb && (r_stk_cnt == STK_W'(STUCK_CYCLES - 1))) begin
        r_stuck <= 1'b1;
      end
    end
  end

  // Rise is taken from the flip itself so the pending flag is set on the
  // same edge the debounced level goes high.
  assign o_rise_c = w_flip & w_synced & ~r_stuck;
  assign o_stuck  = r_stuck;

endmodule

module coin_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_nickle_raw,
  input  logic       i_dime_raw,
  input  logic       i_quarter_raw,
  output logic       o_nickle,
  output logic       o_dime,
  output logic       o_quarter,
  output logic       o_busy,
  output logic [2:0] o_stuck
);

  localparam int unsigned NCH = 3;

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] w_rise;
  logic [NCH-1:0] w_stuck;
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] w_avail;
  logic [NCH-1:0] w_grant;
  logic [NCH-1:0] w_pend_nxt;
  logic           r_nickle;
  logic           r_dime;
  logic           r_quarter;
  logic           r_busy;

  assign w_raw = {i_quarter_raw, i_dime_raw, i_nickle_raw};

  // One conditioning channel per slot; bit order nickel, dime, quarter.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    coin_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raw    (w_raw[g]),
      .o_rise_c (w_rise[g]),
      .o_stuck  (w_stuck[g])
    );
  end

  // Fixed-priority grant; a new rise on the granted channel re-arms its
  // pending flag so a coin is never lost on a same-edge set/clear.
  always_comb begin
    w_grant = '0;
    w_avail = r_pend & ~w_stuck;
    if (w_avail[0]) begin
      w_grant = 3'b001;
    end else if (w_avail[1]) begin
      w_grant = 3'b010;
    end else if (w_avail[2]) begin
      w_grant = 3'b100;
    end
    w_pend_nxt = ((r_pend & ~w_grant) | w_rise) & ~w_stuck;
  end

  // Pending flags and registered coin outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend    <= '0;
      r_nickle  <= 1'b0;
      r_dime    <= 1'b0;
      r_quarter <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_pend    <= w_pend_nxt;
      r_nickle  <= w_grant[0];
      r_dime    <= w_grant[1];
      r_quarter <= w_grant[2];
      r_busy    <= |w_avail;
    end
  end

  assign o_nickle  = r_nickle;
  assign o_dime    = r_dime;
  assign o_quarter = r_quarter;
  assign o_busy    = r_busy;
  assign o_stuck   = w_stuck;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_coin_input_conditioner
//   Directed stimulus pushes expected coin pulses (channel, cycle) into a
//   scoreboard queue; an independent negedge monitor pops and compares each
//   pulse the DUT presents, and checks o_busy every cycle.
// ---------------------------------------------------------------------------
module tb_coin_input_conditioner;

  typedef struct {
    logic [2:0] ch;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       nickle_raw, dime_raw, quarter_raw;
  logic       o_nickle, o_dime, o_quarter, o_busy;
  logic [2:0] o_stuck;

  int   cyc;
  int   checks;
  int   errors;
  int   pcnt [3];
  int   bcnt;
  exp_t sb [$];

  logic [2:0] mon_out;
  exp_t       mon_e;
  logic       mon_busy_exp;

  coin_input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .STUCK_CYCLES    (50)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_nickle_raw  (nickle_raw),
    .i_dime_raw    (dime_raw),
    .i_quarter_raw (quarter_raw),
    .o_nickle      (o_nickle),
    .o_dime        (o_dime),
    .o_quarter     (o_quarter),
    .o_busy        (o_busy),
    .o_stuck       (o_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares pulses against the scoreboard, checks busy each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        check("missed_pulse_cycle", cyc, mon_e.cyc);
      end
      mon_out      = {o_quarter, o_dime, o_nickle};
      mon_busy_exp = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("busy", int'(o_busy), int'(mon_busy_exp));
      if (o_busy) bcnt++;
      if (mon_out != 3'b000) begin
        pcnt[0] += int'(o_nickle);
        pcnt[1] += int'(o_dime);
        pcnt[2] += int'(o_quarter);
        check("onehot", $countones(mon_out), 1);
        if (sb.size() == 0) begin
          check("unexpected_pulse", int'(mon_out), 0);
        end else if (sb[0].cyc == cyc) begin
          mon_e = sb.pop_front();
          check("pulse_channel", int'(mon_out), int'(mon_e.ch));
        end else begin
          check("early_pulse_cycle", cyc, sb[0].cyc);
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] ch, input int c);
    exp_t e;
    e.ch  = ch;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulses"}, int'({o_quarter, o_dime, o_nickle}), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_stuck"}, int'(o_stuck), 0);
  endtask

  initial begin
    int c;
    int b [3];
    int bb;
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    bcnt        = 0;
    pcnt        = '{0, 0, 0};
    rst         = 1'b1;
    nickle_raw  = 1'b0;
    dime_raw    = 1'b0;
    quarter_raw = 1'b0;

    // Reset state
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(5);

    // Single clean nickel
    b = pcnt; bb = bcnt; c = cyc;
    push(3'b001, c + 7);
    nickle_raw = 1'b1;
    idle(20);
    nickle_raw = 1'b0;
    idle(20);
    check("nickel_single_n", pcnt[0] - b[0], 1);
    check("nickel_single_d", pcnt[1] - b[1], 0);
    check("nickel_single_q", pcnt[2] - b[2], 0);
    check("nickel_single_busy_cycles", bcnt - bb, 1);

    // Bounce rejection on dime, then a clean dime
    b = pcnt;
    for (int i = 0; i < 10; i++) begin
      dime_raw = ~dime_raw;
      idle(1);
    end
    dime_raw = 1'b0;
    idle(15);
    check("bounce_no_pulse", (pcnt[0] - b[0]) + (pcnt[1] - b[1]) + (pcnt[2] - b[2]), 0);
    c = cyc;
    push(3'b010, c + 7);
    dime_raw = 1'b1;
    idle(10);
    dime_raw = 1'b0;
    idle(20);
    check("dime_after_bounce", pcnt[1] - b[1], 1);

    // Simultaneous coins
    b = pcnt; bb = bcnt; c = cyc;
    push(3'b001, c + 7);
    push(3'b010, c + 8);
    push(3'b100, c + 9);
    nickle_raw = 1'b1; dime_raw = 1'b1; quarter_raw = 1'b1;
    idle(20);
    nickle_raw = 1'b0; dime_raw = 1'b0; quarter_raw = 1'b0;
    idle(20);
    check("simul_n", pcnt[0] - b[0], 1);
    check("simul_d", pcnt[1] - b[1], 1);
    check("simul_q", pcnt[2] - b[2], 1);
    check("simul_busy_cycles", bcnt - bb, 3);

    // Long quarter hold (below stuck threshold) then release
    b = pcnt; c = cyc;
    push(3'b100, c + 7);
    quarter_raw = 1'b1;
    idle(40);
    quarter_raw = 1'b0;
    idle(20);
    check("long_hold_q", pcnt[2] - b[2], 1);
    check("long_hold_stuck", int'(o_stuck), 0);

    // Stuck nickel: debounced rises at c+6, stuck flag 50 edges later
    b = pcnt; c = cyc;
    push(3'b001, c + 7);
    nickle_raw = 1'b1;
    wait_cyc(c + 55);
    check("stuck_before_threshold", int'(o_stuck), 0);
    wait_cyc(c + 56);
    check("stuck_at_threshold", int'(o_stuck), 1);
    wait_cyc(c + 100);
    nickle_raw = 1'b0;
    idle(20);
    check("stuck_nickel_one_pulse", pcnt[0] - b[0], 1);
    b = pcnt; c = cyc;
    push(3'b010, c + 7);
    dime_raw = 1'b1;
    idle(10);
    dime_raw = 1'b0;
    idle(20);
    check("dime_while_nickel_stuck", pcnt[1] - b[1], 1);
    b = pcnt;
    nickle_raw = 1'b1;
    idle(20);
    nickle_raw = 1'b0;
    idle(20);
    check("stuck_nickel_masked", pcnt[0] - b[0], 0);
    check("stuck_sticky", int'(o_stuck), 1);

    // Reset mid-operation with raw dime held through release
    b = pcnt; c = cyc;
    dime_raw = 1'b1;
    wait_cyc(c + 2);
    rst = 1'b1;
    wait_cyc(c + 3);
    check_reset_outputs("midreset");
    wait_cyc(c + 5);
    rst = 1'b0;
    push(3'b010, c + 12);
    wait_cyc(c + 20);
    dime_raw = 1'b0;
    idle(20);
    check("midreset_dime", pcnt[1] - b[1], 1);
    check("midreset_stuck_cleared", int'(o_stuck), 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
